nibble_serial_add8: RTL and testbench

NIBBLE_SERIAL_ADD8 -- requirements
Module: nibble_serial_add8

---
 rtl/nibble_serial_add8.sv | 140 ++++++++++++++
 tb/tb_nibble_serial_add8.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add8.sv
// 8-bit add/subtract built from one shared 4-bit ripple adder, low nibble first.
// Valid/ready handshake on both sides; one operation in flight at a time.

module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];
endmodule

module nibble_serial_add8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ovf,
  output logic       zero
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic signed [7:0] r_a;
  logic signed [7:0] r_b_eff;
  logic              r_cin_eff;
  logic              r_carry_lo;
  logic        [7:0] r_sum;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;

  logic [3:0] w_add_a;
  logic [3:0] w_add_b;
  logic       w_add_cin;
  logic [3:0] w_add_s;
  logic       w_add_cout;
  logic       w_accept;
  logic [7:0] w_sum_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = LO;
      LO:      w_next = HI;
      HI:      w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  assign w_accept = in_valid && in_ready;

  // Operand select for the shared nibble adder: high nibble only in HI.
  always_comb begin
    w_add_a   = r_a[3:0];
    w_add_b   = r_b_eff[3:0];
    w_add_cin = r_cin_eff;
    if (r_state == HI) begin
      w_add_a   = r_a[7:4];
      w_add_b   = r_b_eff[7:4];
      w_add_cin = r_carry_lo;
    end
  end

  adder_4bit u_adder (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .s    (w_add_s),
    .cout (w_add_cout)
  );

  assign w_sum_full = {w_add_s, r_sum[3:0]};

  // Subtraction is A + ~B + 1, so cout=1 means no borrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b_eff    <= '0;
      r_cin_eff  <= 1'b0;
      r_carry_lo <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a       <= a;
        r_b_eff   <= sub ? ~b : b;
        r_cin_eff <= sub ? 1'b1 : cin;
      end
      if (r_state == LO) begin
        r_sum[3:0] <= w_add_s;
        r_carry_lo <= w_add_cout;
      end
      if (r_state == HI) begin
        r_sum[7:4] <= w_add_s;
        r_cout     <= w_add_cout;
        r_ovf      <= (r_a[7] == r_b_eff[7]) && (w_add_s[3] != r_a[7]);
        r_zero     <= (w_sum_full == 8'h00);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
endmodule

// File: tb/tb_nibble_serial_add8.sv
// Directed and back-to-back bench for nibble_serial_add8 with an expected-result queue.

module tb_nibble_serial_add8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       zero;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
  } res_t;

  res_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  nibble_serial_add8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [7:0] ai, input logic [7:0] bi,
                                 input logic ci, input logic si);
    res_t       r;
    logic [7:0] be;
    logic [8:0] t;
    be  = si ? ~bi : bi;
    t   = {1'b0, ai} + {1'b0, be} + {8'h00, (si ? 1'b1 : ci)};
    r.s = t[7:0];
    r.c = t[8];
    r.o = (ai[7] == be[7]) && (t[7] != ai[7]);
    r.z = (t[7:0] == 8'h00);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag);
    res_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_sum"},  {24'h0, sum}, {24'h0, e.s});
      chk({tag, "_cout"}, {31'h0, cout}, {31'h0, e.c});
      chk({tag, "_ovf"},  {31'h0, ovf},  {31'h0, e.o});
      chk({tag, "_zero"}, {31'h0, zero}, {31'h0, e.z});
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  task automatic do_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                       input logic ci, input logic si, input int hold);
    logic [7:0] s_keep;
    logic [2:0] f_keep;
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1;
    q.push_back(model(ai, bi, ci, si));
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    chk({tag, "_lo_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_lo_ready"}, {31'h0, in_ready}, 32'h0);
    @(negedge clk);
    chk({tag, "_hi_valid"}, {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk({tag, "_done_valid"}, {31'h0, out_valid}, 32'h1);
    chk_result(tag);
    s_keep = sum;
    f_keep = {cout, ovf, zero};
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        in_valid = ~in_valid;
        a = 8'($urandom); b = 8'($urandom);
        chk({tag, "_bp_valid"}, {31'h0, out_valid}, 32'h1);
        chk({tag, "_bp_ready"}, {31'h0, in_ready}, 32'h0);
        chk({tag, "_bp_sum"},   {24'h0, sum}, {24'h0, s_keep});
        chk({tag, "_bp_flags"}, {29'h0, cout, ovf, zero}, {29'h0, f_keep});
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_idle_ready"}, {31'h0, in_ready}, 32'h1);
    chk({tag, "_idle_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_idle_sum"},   {24'h0, sum}, {24'h0, s_keep});
  endtask

  initial begin
    int last_acc;
    @(negedge clk);
    chk("rst_in_ready",  {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_sum",       {24'h0, sum}, 32'h0);
    chk("rst_flags",     {29'h0, cout, ovf, zero}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_op("add_3c_45", 8'h3C, 8'h45, 1'b0, 1'b0, 0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op("add_0f_c1", 8'h0F, 8'h00, 1'b1, 1'b0, 0);
    do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 0);
    do_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 0);
    do_op("backpress", 8'h7F, 8'h01, 1'b0, 1'b0, 5);

    // Abort an operation while the high nibble is being computed.
    a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    q.push_back(model(8'h55, 8'h22, 1'b0, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_in_ready",  {31'h0, in_ready}, 32'h1);
    chk("midrst_sum",       {24'h0, sum}, 32'h0);
    chk("midrst_flags",     {29'h0, cout, ovf, zero}, 32'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 0);

    // Back-to-back with in_valid held high and operands changing every cycle.
    last_acc  = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (out_valid) chk_result("b2b");
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (in_ready) begin
        q.push_back(model(a, b, cin, sub));
        if (last_acc >= 0) chk("b2b_gap", 32'(cyc - last_acc), 32'd4);
        last_acc = cyc;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) chk_result("b2b_drain");
      @(negedge clk);
    end
    chk("b2b_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
